// File: rtl/delta_irq_pkg.sv
// Shared types and constants for the delta-register interrupt controller.
package delta_irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    CLEAR   = 2'd2,
    HOLDOFF = 2'd3
  } irq_state_e;

  localparam int unsigned HOLDOFF_W = 8;

endpackage

// File: rtl/delta_irq_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the
// pointer, wrapping to index 0 when nothing is set in the upper segment.
module rr_arbiter #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_grant_idx,
  output logic         o_grant_vld
);

  // Scan [ptr..N-1] first, then [0..ptr-1]; the first hit wins.
  always_comb begin
    o_grant_idx = '0;
    o_grant_vld = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!o_grant_vld && i_req[j] && (W'(j) >= i_ptr)) begin
        o_grant_idx = W'(j);
        o_grant_vld = 1'b1;
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!o_grant_vld && i_req[j] && (W'(j) < i_ptr)) begin
        o_grant_idx = W'(j);
        o_grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delta_irq_ctrl.sv
// Interrupt controller for a bank of delta registers: round-robin selection
// among unmasked change flags, one IRQ at a time, READ_EVENT clear pulse on
// host acknowledge, and a hold-off gap before the next arbitration.
module delta_irq_ctrl
  import delta_irq_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = 8,
  parameter int unsigned IDX_WIDTH   = $clog2(NUM_SOURCES),
  parameter int unsigned IRQ_HOLDOFF = 4
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic [NUM_SOURCES-1:0] VALUE_CHANGE_IN,
  input  logic [NUM_SOURCES-1:0] IRQ_MASK,
  output logic [NUM_SOURCES-1:0] READ_EVENT_OUT,
  output logic                   IRQ,
  output logic [IDX_WIDTH-1:0]   IRQ_ID,
  input  logic                   IRQ_ACK,
  output logic [NUM_SOURCES-1:0] PENDING
);

  irq_state_e             r_state;
  logic                   r_irq;
  logic [IDX_WIDTH-1:0]   r_irq_id;
  logic [NUM_SOURCES-1:0] r_read_event;
  logic [NUM_SOURCES-1:0] r_pending;
  logic [IDX_WIDTH-1:0]   r_rr_ptr;
  logic [HOLDOFF_W-1:0]   r_holdoff_cnt;

  logic [NUM_SOURCES-1:0] w_cand;
  logic [IDX_WIDTH-1:0]   w_grant_idx;
  logic                   w_grant_vld;
  logic [IDX_WIDTH-1:0]   w_rr_next;

  assign w_cand = VALUE_CHANGE_IN & ~IRQ_MASK;

  rr_arbiter #(
    .N (NUM_SOURCES),
    .W (IDX_WIDTH)
  ) u_rr_arbiter (
    .i_req       (w_cand),
    .i_ptr       (r_rr_ptr),
    .o_grant_idx (w_grant_idx),
    .o_grant_vld (w_grant_vld)
  );

  // Pointer advances past the serviced source, wrapping at NUM_SOURCES
  // (explicit compare so non-power-of-two counts wrap correctly).
  always_comb begin
    w_rr_next = r_irq_id + 1'b1;
    if (r_irq_id == IDX_WIDTH'(NUM_SOURCES - 1)) begin
      w_rr_next = '0;
    end
  end

  // Service FSM with registered outputs and pending-status register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state       <= IDLE;
      r_irq         <= 1'b0;
      r_irq_id      <= '0;
      r_read_event  <= '0;
      r_pending     <= '0;
      r_rr_ptr      <= '0;
      r_holdoff_cnt <= '0;
    end else begin
      r_pending <= w_cand;
      case (r_state)
        IDLE: begin
          if (w_grant_vld) begin
            r_irq_id <= w_grant_idx;
            r_irq    <= 1'b1;
            r_state  <= ASSERT;
          end
        end
        ASSERT: begin
          if (IRQ_ACK) begin
            r_irq        <= 1'b0;
            r_read_event <= NUM_SOURCES'(1) << r_irq_id;
            r_state      <= CLEAR;
          end
        end
        CLEAR: begin
          r_read_event  <= '0;
          r_rr_ptr      <= w_rr_next;
          r_holdoff_cnt <= HOLDOFF_W'(IRQ_HOLDOFF - 1);
          r_state       <= HOLDOFF;
        end
        HOLDOFF: begin
          if (r_holdoff_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_holdoff_cnt <= r_holdoff_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign READ_EVENT_OUT = r_read_event;
  assign IRQ            = r_irq;
  assign IRQ_ID         = r_irq_id;
  assign PENDING        = r_pending;

  a_read_event_onehot0: assert property (@(posedge CLK) disable iff (!RSTN)
    $onehot0(READ_EVENT_OUT));
  a_read_event_in_clear: assert property (@(posedge CLK) disable iff (!RSTN)
    (READ_EVENT_OUT != '0) |-> (r_state == CLEAR));
  a_irq_matches_state: assert property (@(posedge CLK) disable iff (!RSTN)
    IRQ == (r_state == ASSERT));

endmodule

// File: tb/tb_delta_irq_ctrl.sv
// Directed bench for delta_irq_ctrl (8 sources, hold-off 4).
module tb_delta_irq_ctrl;

  logic       CLK;
  logic       RSTN;
  logic [7:0] VALUE_CHANGE_IN;
  logic [7:0] IRQ_MASK;
  logic [7:0] READ_EVENT_OUT;
  logic       IRQ;
  logic [2:0] IRQ_ID;
  logic       IRQ_ACK;
  logic [7:0] PENDING;

  int checks = 0;
  int errors = 0;

  delta_irq_ctrl #(
    .NUM_SOURCES (8),
    .IDX_WIDTH   (3),
    .IRQ_HOLDOFF (4)
  ) dut (
    .CLK             (CLK),
    .RSTN            (RSTN),
    .VALUE_CHANGE_IN (VALUE_CHANGE_IN),
    .IRQ_MASK        (IRQ_MASK),
    .READ_EVENT_OUT  (READ_EVENT_OUT),
    .IRQ             (IRQ),
    .IRQ_ID          (IRQ_ID),
    .IRQ_ACK         (IRQ_ACK),
    .PENDING         (PENDING)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge CLK);
  endtask

  // Acknowledge the active IRQ, act as the delta register (drop the flag that
  // received READ_EVENT), optionally re-raise flags during hold-off, and
  // return with the controller back in IDLE.
  task automatic do_ack(input logic [7:0] reraise, output logic [7:0] re_seen);
    IRQ_ACK = 1'b1;
    tick();
    IRQ_ACK = 1'b0;
    re_seen = READ_EVENT_OUT;
    VALUE_CHANGE_IN = VALUE_CHANGE_IN & ~re_seen;
    tick();
    VALUE_CHANGE_IN = VALUE_CHANGE_IN | reraise;
    repeat (4) tick();
  endtask

  task automatic test_reset;
    RSTN = 1'b0;
    VALUE_CHANGE_IN = '0;
    IRQ_MASK = '0;
    IRQ_ACK = 1'b0;
    tick();
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0h expected 0", IRQ); end
    checks++; if (IRQ_ID !== 3'd0) begin errors++; $display("FAIL reset_id: got %0h expected 0", IRQ_ID); end
    checks++; if (READ_EVENT_OUT !== 8'h00) begin errors++; $display("FAIL reset_re: got %0h expected 0", READ_EVENT_OUT); end
    checks++; if (PENDING !== 8'h00) begin errors++; $display("FAIL reset_pending: got %0h expected 0", PENDING); end
    RSTN = 1'b1;
  endtask

  task automatic test_single;
    logic [7:0] re;
    VALUE_CHANGE_IN = 8'h04;
    tick();
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL single_irq: got %0h expected 1", IRQ); end
    checks++; if (IRQ_ID !== 3'd2) begin errors++; $display("FAIL single_id: got %0h expected 2", IRQ_ID); end
    checks++; if (PENDING !== 8'h04) begin errors++; $display("FAIL single_pending: got %0h expected 04", PENDING); end
    tick();
    checks++; if (IRQ !== 1'b1 || IRQ_ID !== 3'd2) begin errors++; $display("FAIL single_hold: got irq %0h id %0h expected 1/2", IRQ, IRQ_ID); end
    IRQ_ACK = 1'b1;
    tick();
    IRQ_ACK = 1'b0;
    checks++; if (READ_EVENT_OUT !== 8'h04) begin errors++; $display("FAIL single_re: got %0h expected 04", READ_EVENT_OUT); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL single_irq_drop: got %0h expected 0", IRQ); end
    VALUE_CHANGE_IN = 8'h00;
    tick();
    checks++; if (READ_EVENT_OUT !== 8'h00) begin errors++; $display("FAIL single_re_width: got %0h expected 00", READ_EVENT_OUT); end
    VALUE_CHANGE_IN = 8'h04;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL single_holdoff%0d: got %0h expected 0", i, IRQ); end
    end
    tick();
    checks++; if (IRQ !== 1'b1 || IRQ_ID !== 3'd2) begin errors++; $display("FAIL single_rearm: got irq %0h id %0h expected 1/2", IRQ, IRQ_ID); end
    do_ack(8'h00, re);
    checks++; if (re !== 8'h04) begin errors++; $display("FAIL single_re2: got %0h expected 04", re); end
  endtask

  task automatic test_round_robin;
    logic [7:0] re;
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
    VALUE_CHANGE_IN = 8'h81;
    tick();
    checks++; if (IRQ !== 1'b1 || IRQ_ID !== 3'd0) begin errors++; $display("FAIL rr_first: got irq %0h id %0h expected 1/0", IRQ, IRQ_ID); end
    do_ack(8'h01, re);
    checks++; if (re !== 8'h01) begin errors++; $display("FAIL rr_re0: got %0h expected 01", re); end
    tick();
    checks++; if (IRQ !== 1'b1 || IRQ_ID !== 3'd7) begin errors++; $display("FAIL rr_second: got irq %0h id %0h expected 1/7", IRQ, IRQ_ID); end
    do_ack(8'h00, re);
    checks++; if (re !== 8'h80) begin errors++; $display("FAIL rr_re7: got %0h expected 80", re); end
    tick();
    checks++; if (IRQ !== 1'b1 || IRQ_ID !== 3'd0) begin errors++; $display("FAIL rr_third: got irq %0h id %0h expected 1/0", IRQ, IRQ_ID); end
    do_ack(8'h00, re);
    checks++; if (re !== 8'h01) begin errors++; $display("FAIL rr_re0b: got %0h expected 01", re); end
  endtask

  task automatic test_mask;
    logic [7:0] re;
    VALUE_CHANGE_IN = 8'hFF;
    IRQ_MASK = 8'hFF;
    repeat (3) tick();
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL mask_all_irq: got %0h expected 0", IRQ); end
    checks++; if (PENDING !== 8'h00) begin errors++; $display("FAIL mask_all_pending: got %0h expected 00", PENDING); end
    VALUE_CHANGE_IN = 8'h04;
    IRQ_MASK = 8'h04;
    repeat (2) tick();
    checks++; if (IRQ !== 1'b0 || PENDING !== 8'h00) begin errors++; $display("FAIL mask_one: got irq %0h pending %0h expected 0/00", IRQ, PENDING); end
    IRQ_MASK = 8'h00;
    tick();
    checks++; if (IRQ !== 1'b1 || IRQ_ID !== 3'd2) begin errors++; $display("FAIL mask_release: got irq %0h id %0h expected 1/2", IRQ, IRQ_ID); end
    checks++; if (PENDING !== 8'h04) begin errors++; $display("FAIL mask_pending: got %0h expected 04", PENDING); end
    do_ack(8'h00, re);
    checks++; if (re !== 8'h04) begin errors++; $display("FAIL mask_re: got %0h expected 04", re); end
  endtask

  task automatic test_mask_in_assert;
    logic [7:0] re;
    VALUE_CHANGE_IN = 8'h08;
    tick();
    checks++; if (IRQ !== 1'b1 || IRQ_ID !== 3'd3) begin errors++; $display("FAIL masa_start: got irq %0h id %0h expected 1/3", IRQ, IRQ_ID); end
    IRQ_MASK = 8'h08;
    VALUE_CHANGE_IN = 8'h28;
    tick();
    checks++; if (IRQ !== 1'b1 || IRQ_ID !== 3'd3) begin errors++; $display("FAIL masa_hold: got irq %0h id %0h expected 1/3", IRQ, IRQ_ID); end
    checks++; if (PENDING !== 8'h20) begin errors++; $display("FAIL masa_pending: got %0h expected 20", PENDING); end
    tick();
    checks++; if (IRQ_ID !== 3'd3) begin errors++; $display("FAIL masa_hold2: got %0h expected 3", IRQ_ID); end
    do_ack(8'h00, re);
    checks++; if (re !== 8'h08) begin errors++; $display("FAIL masa_re: got %0h expected 08", re); end
    tick();
    checks++; if (IRQ !== 1'b1 || IRQ_ID !== 3'd5) begin errors++; $display("FAIL masa_next: got irq %0h id %0h expected 1/5", IRQ, IRQ_ID); end
    do_ack(8'h00, re);
    checks++; if (re !== 8'h20) begin errors++; $display("FAIL masa_re5: got %0h expected 20", re); end
    IRQ_MASK = 8'h00;
  endtask

  task automatic test_ack_ignored;
    logic [7:0] re;
    VALUE_CHANGE_IN = 8'h00;
    IRQ_ACK = 1'b1;
    tick();
    IRQ_ACK = 1'b0;
    checks++; if (READ_EVENT_OUT !== 8'h00 || IRQ !== 1'b0) begin errors++; $display("FAIL ack_idle: got re %0h irq %0h expected 00/0", READ_EVENT_OUT, IRQ); end
    VALUE_CHANGE_IN = 8'h02;
    tick();
    checks++; if (IRQ !== 1'b1 || IRQ_ID !== 3'd1) begin errors++; $display("FAIL ack_wrap: got irq %0h id %0h expected 1/1", IRQ, IRQ_ID); end
    IRQ_ACK = 1'b1;
    tick();
    IRQ_ACK = 1'b0;
    checks++; if (READ_EVENT_OUT !== 8'h02) begin errors++; $display("FAIL ack_re: got %0h expected 02", READ_EVENT_OUT); end
    VALUE_CHANGE_IN = 8'h00;
    tick();
    IRQ_ACK = 1'b1;
    tick();
    IRQ_ACK = 1'b0;
    checks++; if (READ_EVENT_OUT !== 8'h00 || IRQ !== 1'b0) begin errors++; $display("FAIL ack_holdoff: got re %0h irq %0h expected 00/0", READ_EVENT_OUT, IRQ); end
    VALUE_CHANGE_IN = 8'h02;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (IRQ !== 1'b0 || READ_EVENT_OUT !== 8'h00) begin errors++; $display("FAIL ack_holdoff_len%0d: got irq %0h re %0h expected 0/00", i, IRQ, READ_EVENT_OUT); end
    end
    tick();
    checks++; if (IRQ !== 1'b1 || IRQ_ID !== 3'd1) begin errors++; $display("FAIL ack_resume: got irq %0h id %0h expected 1/1", IRQ, IRQ_ID); end
    do_ack(8'h00, re);
    checks++; if (re !== 8'h02) begin errors++; $display("FAIL ack_re2: got %0h expected 02", re); end
  endtask

  task automatic test_async_reset;
    logic [7:0] re;
    VALUE_CHANGE_IN = 8'h10;
    tick();
    checks++; if (IRQ !== 1'b1 || IRQ_ID !== 3'd4) begin errors++; $display("FAIL ares_start: got irq %0h id %0h expected 1/4", IRQ, IRQ_ID); end
    IRQ_ACK = 1'b1;
    tick();
    IRQ_ACK = 1'b0;
    checks++; if (READ_EVENT_OUT !== 8'h10) begin errors++; $display("FAIL ares_re: got %0h expected 10", READ_EVENT_OUT); end
    #2;
    RSTN = 1'b0;
    #1;
    checks++; if (READ_EVENT_OUT !== 8'h00) begin errors++; $display("FAIL ares_re_cut: got %0h expected 00", READ_EVENT_OUT); end
    checks++; if (IRQ !== 1'b0 || IRQ_ID !== 3'd0 || PENDING !== 8'h00) begin errors++; $display("FAIL ares_outs: got irq %0h id %0h pending %0h expected 0/0/00", IRQ, IRQ_ID, PENDING); end
    tick();
    RSTN = 1'b1;
    tick();
    checks++; if (IRQ !== 1'b1 || IRQ_ID !== 3'd4) begin errors++; $display("FAIL ares_rearm: got irq %0h id %0h expected 1/4", IRQ, IRQ_ID); end
    do_ack(8'h00, re);
    checks++; if (re !== 8'h10) begin errors++; $display("FAIL ares_re2: got %0h expected 10", re); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mask();
    test_mask_in_assert();
    test_ack_ignored();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
